aemb_ifetch: RTL
================

AEMB_IFETCH -- requirements
Module: aemb_ifetch

Interface
REQ-001 SHALL: gclk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: grst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: gena  in  1  pipeline advance; with xVLD high, consumes FIFO head.
REQ-004 SHALL: rBRA  in  1  branch taken; flush and redirect fetch.
REQ-005 SHALL: rTGT  in  32  branch target byte address, sampled when rBRA high; bits [1:0] ignored.
REQ-006 SHALL: iwb_stb_o  out  1  instruction Wishbone strobe (classic, single outstanding).
REQ-007 SHALL: iwb_adr_o  out  30  word address [31:2] of current fetch.
REQ-008 SHALL: iwb_ack_i  in  1  fetch acknowledge.
REQ-009 SHALL: iwb_dat_i  in  32  fetched instruction word.
REQ-010 SHALL: xIDAT  out  32  FIFO head instruction, combinational from storage.
REQ-011 SHALL: xVLD  out  1  FIFO non-empty.
REQ-012 SHALL: xPC  out  32  byte address of FIFO head, {stored word address, 2'b00}.

Function
REQ-013 SHALL: prefetch FIFO depth 4 (see REQ-030); entries hold {word address[29:0], instruction[31:0]}; 2-bit read/write pointers wrap 3->0; count 0..4.
REQ-014 SHALL: FSM states RUN and DRAIN only.
REQ-015 SHALL: in RUN, iwb_stb_o = (count < 4); in DRAIN, iwb_stb_o = 1; iwb_stb_o = 0 while grst high.
REQ-016 SHALL: once iwb_stb_o is high, hold it and iwb_adr_o stable until iwb_ack_i, except redirect in RUN on the ack cycle.
REQ-017 SHALL: push on RUN & iwb_stb_o & iwb_ack_i & !rBRA; fetch address then increments by 1 word, wrapping 0x3FFFFFFF -> 0.
REQ-018 SHALL: pop on gena & xVLD & !rBRA; push and pop same cycle leave count unchanged; pop with count 4 and no push allows strobe next cycle.
REQ-019 SHALL: rBRA high: count and pointers cleared next edge, xVLD low following cycle; no pop that cycle.
REQ-020 SHALL: rBRA with iwb_ack_i or !iwb_stb_o: ack data discarded, fetch address <= rTGT[31:2], stay RUN.
REQ-021 SHALL: rBRA with iwb_stb_o & !iwb_ack_i: latch rTGT[31:2] as pending target, enter DRAIN; address on bus unchanged.
REQ-022 SHALL: DRAIN: FIFO neither pushed nor popped; on iwb_ack_i discard data, load fetch address from pending target, return to RUN.
REQ-023 SHALL: rBRA during DRAIN: replace pending target with new rTGT[31:2]; if same cycle as ack, new target wins.
REQ-024 SHALL: ack in RUN with iwb_stb_o low ignored.
REQ-025 SHALL: fetch latency ack edge -> xVLD high one cycle after push (registered count).

Reset
REQ-026 SHALL: on grst: state RUN, fetch address 0, pending target 0, count 0, pointers 0.
REQ-027 SHALL: reset values: iwb_stb_o 0, iwb_adr_o 0, xVLD 0, xPC 0, xIDAT 0 (storage cleared).
REQ-028 SHALL: grst mid-transfer aborts it; an ack in the first post-reset cycle is a fresh ack for address 0.
REQ-029 SHALL: first strobe in first cycle after grst deasserts, address 0.

Configuration
REQ-030 SHALL: macro AEMB_IFETCH_PREFETCH_EN defined: depth 4 per REQ-013; undefined: depth 1, single entry, no pointers, iwb_stb_o in RUN = !xVLD | pop this cycle; all other rules unchanged.

Verification
REQ-031 SHALL: reset, ack every cycle, gena 0 -> addresses 0,1,2,3 fetched, strobe drops at count 4, xPC 0x0, xIDAT first word.
REQ-032 SHALL: ack every cycle, gena 1 -> steady one instruction/cycle, xPC 0x0,0x4,0x8 consecutive, count constant.
REQ-033 SHALL: rBRA with rTGT 0x100 on ack cycle -> data dropped, next iwb_adr_o 0x40, xVLD 0 one cycle, then xPC 0x100.
REQ-034 SHALL: rBRA rTGT 0x200 with strobe pending, ack 3 cycles later -> iwb_stb_o held, iwb_adr_o unchanged, ack data discarded, next iwb_adr_o 0x80.
REQ-035 SHALL: second rBRA rTGT 0x300 during DRAIN -> post-drain fetch address 0xC0.
REQ-036 SHALL: iwb_adr_o 0x3FFFFFFF acked -> next address 0; grst asserted mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/aemb_ifetch.sv
// aemb_ifetch: instruction prefetch with a classic Wishbone fetch port and branch redirect/drain.
// Latency: the ack edge pushes the word and xVLD rises on the cycle after (count is registered).
// Backpressure: the strobe is withheld while the store is full, and gena pops the head.
// Build option: AEMB_IFETCH_PREFETCH_EN selects a 4-deep prefetch FIFO; without it the store is a single entry.
module aemb_ifetch (
    input  logic        gclk,
    input  logic        grst,
    input  logic        gena,
    input  logic        rBRA,
    input  logic [31:0] rTGT,
    output logic        iwb_stb_o,
    output logic [29:0] iwb_adr_o,
    input  logic        iwb_ack_i,
    input  logic [31:0] iwb_dat_i,
    output logic [31:0] xIDAT,
    output logic        xVLD,
    output logic [31:0] xPC
);
    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t      rState, xState;
    logic [29:0] rFADR, xFADR;
    logic [29:0] rPTGT, xPTGT;
    logic        wPush, wPop;

    // Branch targets are word aligned; the byte-lane bits carry no information.
    logic unusedTgtLsb;
    assign unusedTgtLsb = ^rTGT[1:0];

    // Nothing enters or leaves the store while draining a stale fetch.
    assign wPop      = gena & xVLD & ~rBRA & (rState == RUN);
    assign wPush     = (rState == RUN) & iwb_stb_o & iwb_ack_i & ~rBRA;
    assign iwb_adr_o = rFADR;

`ifdef AEMB_IFETCH_PREFETCH_EN
    logic [29:0] rADRS [4];
    logic [31:0] rDATS [4];
    logic [1:0]  rWPTR, rRPTR;
    logic [2:0]  rCNT;

    assign xVLD  = (rCNT != 3'd0);
    assign xIDAT = rDATS[rRPTR];
    assign xPC   = {rADRS[rRPTR], 2'b00};

    // Strobe while there is room; a drain must always see its outstanding cycle through.
    always_comb begin
        iwb_stb_o = 1'b0;
        if (!grst) iwb_stb_o = (rState == DRAIN) | ~rCNT[2];
    end

    // Pointers and occupancy; a taken branch flushes everything in the store.
    always_ff @(posedge gclk) begin
        if (grst || rBRA) begin
            rWPTR <= 2'd0;
            rRPTR <= 2'd0;
            rCNT  <= 3'd0;
        end else begin
            if (wPush) rWPTR <= rWPTR + 2'd1;
            if (wPop)  rRPTR <= rRPTR + 2'd1;
            case ({wPush, wPop})
                2'b10:   rCNT <= rCNT + 3'd1;
                2'b01:   rCNT <= rCNT - 3'd1;
                default: rCNT <= rCNT;
            endcase
        end
    end

    // Entry storage: each word is kept with the address it was fetched from.
    always_ff @(posedge gclk) begin
        if (grst) begin
            for (int i = 0; i < 4; i++) begin
                rADRS[i] <= '0;
                rDATS[i] <= '0;
            end
        end else if (wPush) begin
            rADRS[rWPTR] <= rFADR;
            rDATS[rWPTR] <= iwb_dat_i;
        end
    end
`else
    logic [29:0] rADR;
    logic [31:0] rDAT;
    logic        rFULL;

    assign xVLD  = rFULL;
    assign xIDAT = rDAT;
    assign xPC   = {rADR, 2'b00};

    // Strobe while empty, or when the held word leaves this cycle so its slot frees at the edge.
    always_comb begin
        iwb_stb_o = 1'b0;
        if (!grst) iwb_stb_o = (rState == DRAIN) | ~rFULL | wPop;
    end

    // Occupancy of the single slot; a taken branch empties it.
    always_ff @(posedge gclk) begin
        if (grst || rBRA)  rFULL <= 1'b0;
        else if (wPush)    rFULL <= 1'b1;
        else if (wPop)     rFULL <= 1'b0;
    end

    // Slot storage: the word is kept with the address it was fetched from.
    always_ff @(posedge gclk) begin
        if (grst) begin
            rADR <= '0;
            rDAT <= '0;
        end else if (wPush) begin
            rADR <= rFADR;
            rDAT <= iwb_dat_i;
        end
    end
`endif

    // FSM state, fetch address and pending branch target.
    always_ff @(posedge gclk) begin
        if (grst) begin
            rState <= RUN;
            rFADR  <= '0;
            rPTGT  <= '0;
        end else begin
            rState <= xState;
            rFADR  <= xFADR;
            rPTGT  <= xPTGT;
        end
    end

    // Next state: redirect at once when the bus is free, otherwise park the target until the ack.
    always_comb begin
        xState = rState;
        xFADR  = rFADR;
        xPTGT  = rPTGT;
        case (rState)
            RUN: begin
                if (rBRA) begin
                    if (iwb_ack_i || !iwb_stb_o) begin
                        xFADR = rTGT[31:2];
                    end else begin
                        xPTGT  = rTGT[31:2];
                        xState = DRAIN;
                    end
                end else if (wPush) begin
                    xFADR = rFADR + 30'd1;
                end
            end
            DRAIN: begin
                if (rBRA) xPTGT = rTGT[31:2];
                if (iwb_ack_i) begin
                    xFADR  = rBRA ? rTGT[31:2] : rPTGT;
                    xState = RUN;
                end
            end
            default: xState = RUN;
        endcase
    end
endmodule
